// File: rtl/cache_pkg.sv
// Shared cache geometry and refill state encoding, common to the refill and writeback stages.
package cache_pkg;

    localparam int LINE_WORDS = 8;
    localparam int INDEX_W    = 6;
    localparam int TAG_W      = 21;
    localparam int MEM_AW     = 13;
    localparam int WORD_W     = $clog2(LINE_WORDS);
    localparam int LINE_W     = MEM_AW - WORD_W;
    localparam int TAG_LO_W   = LINE_W - INDEX_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_LAST = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Miss address with the byte offset stripped: {tag, index, word}.
    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [INDEX_W-1:0] index;
        logic [WORD_W-1:0]  word;
    } miss_addr_t;

    // Main-memory line number: the low tag bits sit directly above the index.
    function automatic logic [LINE_W-1:0] mem_line(input miss_addr_t a);
        return {a.tag[TAG_LO_W-1:0], a.index};
    endfunction

endpackage

// File: rtl/cache_refill.sv
// Cache line refill engine: streams one 8-word line from main memory into the
// data RAM, invalidates then revalidates the tag, and forwards the missed word.
module cache_refill
    import cache_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [31:0]             CPU_addr,
    output logic [MEM_AW-1:0]       main_mem_addr,
    input  logic [31:0]             main_mem_dout,
    output logic                    cache_data_we,
    output logic [INDEX_W+WORD_W-1:0] cache_data_addr,
    output logic [31:0]             cache_data_din,
    output logic                    tag_we,
    output logic [INDEX_W-1:0]      tag_addr,
    output logic [TAG_W:0]          tag_din,
    output logic                    fwd_valid,
    output logic [31:0]             fwd_data,
    output logic                    busy,
    output logic                    done
);

    logic [1:0]        state;
    logic [WORD_W-1:0] cnt;
    miss_addr_t        line_q;
    logic              wr_vld;
    logic [WORD_W-1:0] wr_word;
    logic              in_fill;
    logic              unused_byte_off;

    assign unused_byte_off = ^CPU_addr[1:0];
    assign in_fill         = (state == ST_FILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            line_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        line_q <= miss_addr_t'(CPU_addr[31:2]);
                        state  <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == WORD_W'(LINE_WORDS - 1))
                        state <= ST_LAST;
                end
                ST_LAST: state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Memory data lags its address by one cycle, so the data RAM write trails
    // each FILL cycle; the final write lands in LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_vld  <= 1'b0;
            wr_word <= '0;
        end else begin
            wr_vld  <= in_fill;
            wr_word <= cnt;
        end
    end

    assign main_mem_addr   = in_fill ? {mem_line(line_q), cnt} : '0;

    assign cache_data_we   = wr_vld;
    assign cache_data_addr = wr_vld ? {line_q.index, wr_word} : '0;
    assign cache_data_din  = main_mem_dout;

    // Invalidate before the first data write so an aborted refill never looks valid.
    assign tag_we          = (in_fill && cnt == '0) || (state == ST_LAST);
    assign tag_addr        = tag_we ? line_q.index : '0;
    assign tag_din         = tag_we ? {(state == ST_LAST), line_q.tag} : '0;

    assign fwd_valid       = wr_vld && (wr_word == line_q.word);
    assign fwd_data        = fwd_valid ? main_mem_dout : '0;

    assign busy            = (state != ST_IDLE);
    assign done            = (state == ST_DONE);

endmodule

// File: tb/tb_cache_refill.sv
// Directed bench for cache_refill: normal fill, forwarding, busy rejection,
// mid-refill reset and back-to-back refills at the top index.
module tb_cache_refill;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] CPU_addr;
    logic [12:0] main_mem_addr;
    logic [31:0] main_mem_dout = 32'h0;
    logic        cache_data_we;
    logic [8:0]  cache_data_addr;
    logic [31:0] cache_data_din;
    logic        tag_we;
    logic [5:0]  tag_addr;
    logic [21:0] tag_din;
    logic        fwd_valid;
    logic [31:0] fwd_data;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    logic        mon_clr = 1'b0;
    int          n_done, n_fwd, n_we, n_tag;
    logic [21:0] last_tag;

    cache_refill dut (
        .clk(clk), .rst_n(rst_n), .start(start), .CPU_addr(CPU_addr),
        .main_mem_addr(main_mem_addr), .main_mem_dout(main_mem_dout),
        .cache_data_we(cache_data_we), .cache_data_addr(cache_data_addr),
        .cache_data_din(cache_data_din), .tag_we(tag_we), .tag_addr(tag_addr),
        .tag_din(tag_din), .fwd_valid(fwd_valid), .fwd_data(fwd_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Main memory: returns 0xA5000000 + word one cycle after the address.
    always @(posedge clk)
        main_mem_dout <= 32'hA500_0000 + {29'b0, main_mem_addr[2:0]};

    always @(negedge clk) begin
        if (mon_clr) begin
            n_done = 0; n_fwd = 0; n_we = 0; n_tag = 0; last_tag = '0;
        end else begin
            if (done)          n_done = n_done + 1;
            if (fwd_valid)     n_fwd  = n_fwd + 1;
            if (cache_data_we) n_we   = n_we + 1;
            if (tag_we) begin  n_tag  = n_tag + 1; last_tag = tag_din; end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one cycle; leaves time 1 unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic mon_reset();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; CPU_addr = 32'h0; cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_mma", {19'b0, main_mem_addr}, 32'h0);
        chk("rst_we", {30'b0, cache_data_we, tag_we}, 32'h0);
        chk("rst_fwd", {31'b0, fwd_valid}, 32'h0);
        rst_n = 1'b1;
        tick();

        // A: normal fill + forwarding, addr 0x1234 -> index 17, tag 2, word 5, line 0x91
        mon_reset();
        CPU_addr = 32'h0000_1234; start = 1'b1; cyc = 0;
        chk("A_busy0", {31'b0, busy}, 32'h0);
        for (int c = 1; c <= 12; c++) begin
            tick();
            start = 1'b0; CPU_addr = 32'hDEAD_BEEF;
            case (cyc)
                1: begin
                    chk("A_mma1", {19'b0, main_mem_addr}, 32'h488);
                    chk("A_tagwe1", {31'b0, tag_we}, 32'h1);
                    chk("A_tagdin1", {10'b0, tag_din}, 32'h2);
                    chk("A_tagaddr1", {26'b0, tag_addr}, 32'd17);
                    chk("A_busy1", {31'b0, busy}, 32'h1);
                end
                2: begin
                    chk("A_cwe2", {31'b0, cache_data_we}, 32'h1);
                    chk("A_caddr2", {23'b0, cache_data_addr}, 32'h088);
                    chk("A_cdin2", cache_data_din, 32'hA500_0000);
                end
                7: begin
                    chk("A_fwd7", {31'b0, fwd_valid}, 32'h1);
                    chk("A_fwddata7", fwd_data, 32'hA500_0005);
                end
                8: chk("A_mma8", {19'b0, main_mem_addr}, 32'h48F);
                9: begin
                    chk("A_caddr9", {23'b0, cache_data_addr}, 32'h08F);
                    chk("A_tagwe9", {31'b0, tag_we}, 32'h1);
                    chk("A_tagdin9", {10'b0, tag_din}, 32'h20_0002);
                    chk("A_tagaddr9", {26'b0, tag_addr}, 32'd17);
                end
                10: chk("A_done10", {31'b0, done}, 32'h1);
                11: begin
                    chk("A_busy11", {31'b0, busy}, 32'h0);
                    chk("A_done11", {31'b0, done}, 32'h0);
                end
                default: ;
            endcase
        end
        chk("A_n_we", n_we, 32'd8);
        chk("A_n_fwd", n_fwd, 32'd1);
        chk("A_n_done", n_done, 32'd1);
        chk("A_n_tag", n_tag, 32'd2);

        // B: start re-asserted with another address while busy
        mon_reset();
        CPU_addr = 32'h0000_1234; start = 1'b1; cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            start = (cyc >= 2 && cyc <= 4);
            CPU_addr = (cyc >= 2) ? 32'hFFFF_FFE0 : 32'h0000_1234;
            case (cyc)
                5: chk("B_mma5", {19'b0, main_mem_addr}, 32'h48C);
                9: chk("B_tagdin9", {10'b0, tag_din}, 32'h20_0002);
                default: ;
            endcase
        end
        start = 1'b0;
        chk("B_n_done", n_done, 32'd1);
        chk("B_n_we", n_we, 32'd8);

        // C: reset asserted during cycle 5 of a refill
        mon_reset();
        CPU_addr = 32'h0000_1234; start = 1'b1; cyc = 0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("C_busy", {31'b0, busy}, 32'h0);
        chk("C_mma", {19'b0, main_mem_addr}, 32'h0);
        chk("C_cwe", {31'b0, cache_data_we}, 32'h0);
        chk("C_caddr", {23'b0, cache_data_addr}, 32'h0);
        chk("C_tag", {9'b0, tag_we, tag_addr, tag_din}, 32'h0);
        chk("C_fwd", {31'b0, fwd_valid}, 32'h0);
        chk("C_done", {31'b0, done}, 32'h0);
        repeat (8) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("C_last_tag", {10'b0, last_tag}, 32'h2);
        chk("C_n_tag", n_tag, 32'd1);
        chk("C_n_done", n_done, 32'd0);
        chk("C_busy_after", {31'b0, busy}, 32'h0);

        // D: start held high, top address -> index 63, line 0x3FF, word 7
        mon_reset();
        CPU_addr = 32'hFFFF_FFFC; start = 1'b1; cyc = 0;
        chk("D_busy0", {31'b0, busy}, 32'h0);
        for (int c = 1; c <= 21; c++) begin
            tick();
            case (cyc)
                1: begin
                    chk("D_mma1", {19'b0, main_mem_addr}, 32'h1FF8);
                    chk("D_tagaddr1", {26'b0, tag_addr}, 32'd63);
                    chk("D_tagdin1", {10'b0, tag_din}, 32'h1F_FFFF);
                end
                8: chk("D_mma8", {19'b0, main_mem_addr}, 32'h1FFF);
                9: begin
                    chk("D_fwd9", {31'b0, fwd_valid}, 32'h1);
                    chk("D_fwddata9", fwd_data, 32'hA500_0007);
                    chk("D_caddr9", {23'b0, cache_data_addr}, 32'h1FF);
                    chk("D_tagdin9", {10'b0, tag_din}, 32'h3F_FFFF);
                end
                10: chk("D_done10", {31'b0, done}, 32'h1);
                11: chk("D_busy11", {31'b0, busy}, 32'h0);
                12: begin
                    chk("D_busy12", {31'b0, busy}, 32'h1);
                    chk("D_mma12", {19'b0, main_mem_addr}, 32'h1FF8);
                end
                21: chk("D_done21", {31'b0, done}, 32'h1);
                default: ;
            endcase
        end
        start = 1'b0;
        tick();
        chk("D_n_fwd", n_fwd, 32'd2);
        chk("D_n_done", n_done, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
